// File: rtl/inst_rom_loader.sv
// inst_rom_loader: boot-time instruction memory loader.
// Receives a byte-stream program image over a valid/ready interface, packs
// it little-endian into 32-bit words, holds the core in reset while loading,
// then serves combinational instruction fetches once released.
// DEPTH must be a power of two and at least 4.
// Optional feature: define INST_ROM_CHECKSUM_EN to require a trailing
// checksum byte (two's complement of the mod-256 byte sum) before release.
module inst_rom_loader #(
    parameter int          DEPTH = 4096,
    parameter logic [31:0] NOP   = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_addr_i,
    output logic [31:0] inst_o,
    input  logic        ld_valid_i,
    output logic        ld_ready_o,
    input  logic [7:0]  ld_byte_i,
    input  logic        ld_last_i,
    output logic        core_rst_o,
    output logic        load_done_o,
    output logic        load_err_o
);

    localparam int AW = $clog2(DEPTH);

`ifdef INST_ROM_CHECKSUM_EN
    typedef enum logic [1:0] {ST_LOAD, ST_CHECK, ST_RUN, ST_ERR} state_t;
`else
    typedef enum logic [1:0] {ST_LOAD, ST_RUN, ST_ERR} state_t;
`endif

    state_t          r_state;
    state_t          w_state_nxt;

    logic [AW:0]     r_wptr;
    logic [1:0]      r_bcnt;
    logic [31:0]     r_asm;
    logic            r_err;
    logic [DEPTH-1:0] r_vld;
    logic [31:0]     r_mem [DEPTH];

    logic            w_full;
    logic            w_img_acc;
    logic            w_wr_en;
    logic            w_err_set;
    logic [31:0]     w_word;
    logic [AW-1:0]   w_raddr;
    logic            w_in_range;
    logic [1:0]      w_unused_addr;

`ifdef INST_ROM_CHECKSUM_EN
    logic [7:0]      r_sum;
    logic [7:0]      w_sum_neg;

    assign w_sum_neg = 8'(~r_sum + 8'd1);
`endif

    // Memory is full once every word slot has been written.
    assign w_full = (r_wptr == (AW+1)'(DEPTH));

    // Merge the incoming byte into the partial word; upper lanes of r_asm are
    // still zero, which gives zero padding for a short final word for free.
    assign w_word = r_asm | ({24'd0, ld_byte_i} << {r_bcnt, 3'b000});

    // Fetch side: byte offset bits are don't-care, anything past the array is NOP.
    assign w_raddr       = inst_addr_i[AW+1:2];
    assign w_in_range    = ((inst_addr_i >> (AW + 2)) == 32'd0);
    assign w_unused_addr = inst_addr_i[1:0];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic, handshake and write/error decisions.
    always_comb begin
        w_state_nxt = r_state;
        ld_ready_o  = 1'b0;
        w_img_acc   = 1'b0;
        w_wr_en     = 1'b0;
        w_err_set   = 1'b0;
        case (r_state)
            ST_LOAD: begin
                ld_ready_o = 1'b1;
                if (ld_valid_i) begin
                    // Any byte accepted with the array full can only end in a
                    // word write past the end, so flag the overflow right away.
                    if (w_full) begin
                        w_err_set   = 1'b1;
                        w_state_nxt = ST_ERR;
                    end else begin
                        w_img_acc = 1'b1;
                        if ((r_bcnt == 2'd3) || ld_last_i) begin
                            w_wr_en = 1'b1;
                        end
                        if (ld_last_i) begin
`ifdef INST_ROM_CHECKSUM_EN
                            w_state_nxt = ST_CHECK;
`else
                            w_state_nxt = ST_RUN;
`endif
                        end
                    end
                end
            end
`ifdef INST_ROM_CHECKSUM_EN
            ST_CHECK: begin
                ld_ready_o = 1'b1;
                if (ld_valid_i) begin
                    if (ld_byte_i == w_sum_neg) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_err_set   = 1'b1;
                        w_state_nxt = ST_ERR;
                    end
                end
            end
`endif
            ST_RUN: begin
                w_state_nxt = ST_RUN;
            end
            ST_ERR: begin
                w_state_nxt = ST_ERR;
            end
            default: begin
                w_state_nxt = ST_LOAD;
            end
        endcase
    end

    // Load control: byte assembly, word pointer, valid bits and error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_bcnt <= 2'd0;
            r_asm  <= 32'd0;
            r_err  <= 1'b0;
            r_vld  <= '0;
        end else begin
            if (w_err_set) begin
                r_err <= 1'b1;
            end
            if (w_img_acc) begin
                if (w_wr_en) begin
                    r_asm                   <= 32'd0;
                    r_bcnt                  <= 2'd0;
                    r_wptr                  <= r_wptr + 1'b1;
                    r_vld[r_wptr[AW-1:0]]   <= 1'b1;
                end else begin
                    r_asm  <= w_word;
                    r_bcnt <= r_bcnt + 2'd1;
                end
            end
        end
    end

`ifdef INST_ROM_CHECKSUM_EN
    // Running mod-256 sum of every accepted image byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum <= 8'd0;
        end else if (w_img_acc) begin
            r_sum <= r_sum + ld_byte_i;
        end
    end
`endif

    // Instruction storage; contents survive reset, r_vld masks stale words.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wptr[AW-1:0]] <= w_word;
        end
    end

    // Combinational fetch port.
    always_comb begin
        inst_o = NOP;
        if ((r_state == ST_RUN) && w_in_range && r_vld[w_raddr]) begin
            inst_o = r_mem[w_raddr];
        end
    end

    assign core_rst_o  = (r_state != ST_RUN);
    assign load_done_o = (r_state == ST_RUN);
    assign load_err_o  = r_err;

endmodule

// File: doc/inst_rom_loader.md
INST_ROM_LOADER -- requirements
Module: inst_rom_loader

Interface
- REQ-001: Parameter DEPTH, default 4096, is the instruction memory size in 32-bit words; it SHALL be a power of two and at least 4.
- REQ-002: Parameter NOP, default 32'h00000013, is the word returned for any fetch that is not served from memory.
- REQ-003: Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
- REQ-004: Port rst, input, 1 bit: reset, synchronous and active-high.
- REQ-005: Port inst_addr_i, input, 32 bits: byte fetch address from the core's fetch stage.
- REQ-006: Port inst_o, output, 32 bits: instruction returned to the core.
- REQ-007: Port ld_valid_i, input, 1 bit: a load byte is offered.
- REQ-008: Port ld_ready_o, output, 1 bit: the block can accept a load byte.
- REQ-009: Port ld_byte_i, input, 8 bits: load data byte.
- REQ-010: Port ld_last_i, input, 1 bit: marks the final image byte.
- REQ-011: Port core_rst_o, output, 1 bit: reset output that holds the core in reset.
- REQ-012: Port load_done_o, output, 1 bit: the image is loaded and the core is released.
- REQ-013: Port load_err_o, output, 1 bit: sticky load-error flag.

Function
- REQ-014: The FSM SHALL have states LOAD, CHECK (present only with the macro), RUN and ERR.
- REQ-015: A byte SHALL be accepted only in a cycle where both ld_valid_i and ld_ready_o are 1.
- REQ-016: ld_ready_o SHALL be 1 in LOAD and CHECK, and 0 in RUN and ERR.
- REQ-017: Accepted bytes SHALL be assembled little-endian: the first byte goes to bits [7:0], the fourth to bits [31:24].
- REQ-018: A 2-bit byte counter SHALL track the assembly position; on the 4th byte, the word SHALL be written at word pointer wptr in that same clock edge, and wptr SHALL increment.
- REQ-019: When the accepted byte has ld_last_i=1, any partial word SHALL be zero-padded and written in that same edge; the next state SHALL be CHECK with the macro, or RUN without it.
- REQ-020: If a word write would occur while wptr equals DEPTH, the write SHALL be dropped, load_err_o SHALL be set and the next state SHALL be ERR.
- REQ-021: core_rst_o SHALL be 1 in every state except RUN, and 0 from the first cycle in RUN onward.
- REQ-022: load_done_o SHALL be 1 only in RUN.
- REQ-023: inst_o SHALL be combinational: it SHALL return mem[inst_addr_i[log2(DEPTH)+1:2]] in RUN when inst_addr_i < 4*DEPTH, and NOP otherwise.
- REQ-024: inst_addr_i[1:0] SHALL be ignored.
- REQ-025: Words never written SHALL read as NOP.
- REQ-026: RUN and ERR SHALL be terminal until rst.
- REQ-027: Bytes offered in RUN or ERR SHALL be ignored and SHALL NOT change memory.

Reset
- REQ-028: On rst=1 at a clock edge, the next state SHALL be: FSM=LOAD, wptr=0, byte counter=0, assembly register=0, checksum=0, load_err_o=0, core_rst_o=1, load_done_o=0, ld_ready_o=1.
- REQ-029: Memory contents SHALL NOT be cleared by reset; a valid-bit per word, cleared on reset, SHALL enforce REQ-025.
- REQ-030: Reset mid-load SHALL discard the partial word and restart the load at word 0.

Configuration
- REQ-031: With macro INST_ROM_CHECKSUM_EN defined, an 8-bit running sum (mod 256) of all accepted image bytes SHALL be kept.
- REQ-032: With INST_ROM_CHECKSUM_EN, the single byte accepted in CHECK SHALL be compared with the two's complement of that sum; on a match the next state SHALL be RUN, otherwise load_err_o SHALL be set and the next state SHALL be ERR.
- REQ-033: Without INST_ROM_CHECKSUM_EN, the CHECK state and the summing logic SHALL be absent, and load_err_o SHALL be set only by the overflow of REQ-020.

Verification
- REQ-034: Reset, then load bytes 13 05 10 00 (last on the 4th), macro off -> mem[0]=0x00100513, core_rst_o falls the cycle after; inst_addr_i=0 -> inst_o=0x00100513.
- REQ-035: Load 5 bytes 01 02 03 04 05 (last on the 5th) -> mem[0]=0x04030201, mem[1]=0x00000005; fetch at address 8 -> inst_o=NOP.
- REQ-036: Apply ld_valid_i with gaps, with rst=1 asserted after 2 bytes, then reload 13 05 10 00 -> mem[0]=0x00100513 and no trace of the aborted bytes.
- REQ-037: With DEPTH=4, load 20 bytes -> load_err_o=1 at the 17th byte, core_rst_o remains 1, and mem[0..3] are intact.
- REQ-038: Macro on: load 13 05 10 00 (sum 0x28), then check byte 0xD8 -> RUN; rerun with check byte 0xD9 -> ERR, load_err_o=1, core_rst_o=1.
- REQ-039: In RUN, fetch at address 0x4000 with DEPTH=4096 -> inst_o=NOP; offered load bytes are ignored (ld_ready_o=0).
